hit_judge: RTL

//  Downstream of the in-game mole manager: consumes mole_pos (0 = none, 1..8 = mole index)
//  and the eight raw hole buttons. Debounces buttons, judges each press as hit or miss,

---
 rtl/hit_judge_if.sv | 23 ++
 rtl/hit_judge.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hit_judge_if.sv
// Game-side bundle for hit_judge: mole position, raw buttons, control and judged results.
interface hit_judge_if #(
  parameter int unsigned SCORE_W = 10
);
  logic               enable;
  logic               score_clr;
  logic [3:0]         mole_pos;
  logic [7:0]         btn_raw;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [3:0]         disp_pos;
  logic [SCORE_W-1:0] score;

  modport master (
    output enable, score_clr, mole_pos, btn_raw,
    input  hit_pulse, miss_pulse, disp_pos, score
  );

  modport slave (
    input  enable, score_clr, mole_pos, btn_raw,
    output hit_pulse, miss_pulse, disp_pos, score
  );
endinterface

// File: rtl/hit_judge.sv
// Debounces hole buttons, judges presses against the current mole, keeps a saturating score.
// Optional MISS_PENALTY_EN: each miss also decrements the score, saturating at zero.
module hit_judge #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned DEBOUNCE_MS = 5,
  parameter int unsigned SCORE_W     = 10
) (
  input logic        clk_1mhz,
  input logic        rst,
  hit_judge_if.slave bus
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_MS + 1);
  localparam logic [TickW-1:0]   TickLast = TickW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]     DbLast   = DbW'(DEBOUNCE_MS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_e;

  logic [7:0]         sync1_q, sync2_q;
  logic [TickW-1:0]   tick_cnt_q;
  logic               tick;
  logic [DbW-1:0]     db_cnt_q [8];
  logic [DbW-1:0]     db_cnt_d [8];
  logic [7:0]         stable_q, stable_d, press_q;
  logic [3:0]         mole_prev_q, mole_eff;
  logic               mole_valid, mole_changed;
  logic [7:0]         hole_mask;
  state_e             state_q, state_eff, state_d;
  logic               hit, miss;
  logic               hit_q, miss_q;
  logic [3:0]         disp_q;
  logic [SCORE_W-1:0] score_q;

  assign tick = (tick_cnt_q == TickLast);

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      stable_q   <= '0;
      press_q    <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= bus.btn_raw;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      stable_q   <= stable_d;
      press_q    <= stable_d & ~stable_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign mole_valid   = (bus.mole_pos != 4'd0) && (bus.mole_pos <= 4'd8);
  assign mole_eff     = mole_valid ? bus.mole_pos : 4'd0;
  assign mole_changed = (mole_eff != mole_prev_q);
  assign hole_mask    = mole_valid ? (8'd1 << (mole_eff - 4'd1)) : 8'd0;

  // A mole change re-arms in the same cycle, so a coincident press is judged on the new mole.
  always_comb begin
    state_eff = state_q;
    if (mole_changed || (state_q == StIdle)) state_eff = mole_valid ? StArmed : StIdle;
    hit     = bus.enable && (state_eff == StArmed) && |(press_q & hole_mask);
    miss    = bus.enable && !hit && |press_q;
    state_d = !bus.enable ? StIdle : (hit ? StLocked : state_eff);
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mole_prev_q <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      disp_q      <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      mole_prev_q <= mole_eff;
      hit_q       <= hit;
      miss_q      <= miss;
      disp_q      <= ((state_d == StLocked) || !bus.enable) ? 4'd0 : mole_eff;
      if (bus.score_clr) begin
        score_q <= '0;
      end else if (hit && (score_q != ScoreMax)) begin
        score_q <= score_q + 1'b1;
      end
`ifdef MISS_PENALTY_EN
      else if (miss && (score_q != '0)) begin
        score_q <= score_q - 1'b1;
      end
`else
`endif
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.disp_pos   = disp_q;
  assign bus.score      = score_q;

endmodule
